// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: op selector, major opcodes, NOP, immediate limits.
// No logic; used by the immediate encoder and the loader top level.
// Keep the op numbering in step with the program-loader front end.
package rv_pkg;

    typedef enum logic [3:0] {
        OP_LUI    = 4'd0,
        OP_AUIPC  = 4'd1,
        OP_JAL    = 4'd2,
        OP_JALR   = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_OPIMM  = 4'd7,
        OP_OP     = 4'd8
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // funct3 values that turn OPIMM into a shift-by-immediate
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    // Signed immediate ranges per format
    localparam logic signed [31:0] I_MIN = -32'sd2048;
    localparam logic signed [31:0] I_MAX = 32'sd2047;
    localparam logic signed [31:0] B_MIN = -32'sd4096;
    localparam logic signed [31:0] B_MAX = 32'sd4094;
    localparam logic signed [31:0] J_MIN = -32'sd1048576;
    localparam logic signed [31:0] J_MAX = 32'sd1048574;

endpackage

// File: rtl/imm_encode.sv
// Places a byte-valued immediate into its RV32I bit positions and flags illegal values.
// Purely combinational, zero latency.
// No flow control; the caller samples the result when it accepts a bundle.
module imm_encode
    import rv_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        illegal
);

    logic signed [31:0] simm;
    logic               is_shift;

    assign simm     = $signed(imm);
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

    // Scatter immediate bits per format; unused positions stay zero for OR-packing
    always_comb begin
        imm_bits = '0;
        illegal  = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                imm_bits = {imm[31:12], 12'b0};
                illegal  = (imm[11:0] != 12'b0);
            end
            OP_JAL: begin
                imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                illegal  = (simm < J_MIN) || (simm > J_MAX) || imm[0];
            end
            OP_BRANCH: begin
                imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                illegal  = (simm < B_MIN) || (simm > B_MAX) || imm[0] ||
                           (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JALR, OP_LOAD: begin
                imm_bits = {imm[11:0], 20'b0};
                illegal  = (simm < I_MIN) || (simm > I_MAX);
            end
            OP_STORE: begin
                imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                illegal  = (simm < I_MIN) || (simm > I_MAX);
            end
            OP_OPIMM: begin
                if (is_shift) begin
                    // Shift amount is unsigned 0..31; anything above bit 4 is out of range
                    imm_bits = {7'b0, imm[4:0], 20'b0};
                    illegal  = (imm[31:5] != 27'b0);
                end else begin
                    imm_bits = {imm[11:0], 20'b0};
                    illegal  = (simm < I_MIN) || (simm > I_MAX);
                end
            end
            OP_OP: begin
                imm_bits = '0;
                illegal  = 1'b0;
            end
            default: begin
                imm_bits = '0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encode_loader.sv
// Encodes symbolic RV32I field bundles into instruction words and addresses them for imem.
// Latency: one cycle from accept to out_valid; full 1 word/cycle throughput.
// Backpressure: in_ready = !out_valid || out_ready; output held stable while stalled.
module inst_encode_loader
    import rv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32,
    parameter int          MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_WORDS - 1);

    logic [31:0]      imm_bits;
    logic             imm_illegal;
    logic [31:0]      word;
    logic [31:0]      next_inst;
    logic             accept;
    logic             xfer;
    logic [IDX_W-1:0] word_idx;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    imm_encode u_imm_encode (
        .op       (in_op),
        .funct3   (in_funct3),
        .imm      (in_imm),
        .imm_bits (imm_bits),
        .illegal  (imm_illegal)
    );

    // Pack register/funct/opcode fields around the pre-placed immediate bits
    always_comb begin
        word = imm_bits;
        case (in_op)
            OP_LUI:    word = imm_bits | {20'b0, in_rd, OPC_LUI};
            OP_AUIPC:  word = imm_bits | {20'b0, in_rd, OPC_AUIPC};
            OP_JAL:    word = imm_bits | {20'b0, in_rd, OPC_JAL};
            OP_JALR:   word = imm_bits | {12'b0, in_rs1, 3'b000, in_rd, OPC_JALR};
            OP_BRANCH: word = imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, OPC_BRANCH};
            OP_LOAD:   word = imm_bits | {12'b0, in_rs1, in_funct3, in_rd, OPC_LOAD};
            OP_STORE:  word = imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, OPC_STORE};
            OP_OPIMM:  word = imm_bits | {1'b0, in_f7b5 && (in_funct3 == F3_SRX), 5'b0,
                                          5'b0, in_rs1, in_funct3, in_rd, OPC_OPIMM};
            OP_OP:     word = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
            default:   word = NOP_INST;
        endcase
        next_inst = imm_illegal ? NOP_INST : word;
    end

    // Output register: load on accept, drop on start, clear valid once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_inst  <= next_inst;
                out_err   <= imm_illegal;
            end else if (start || xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Word address: advance on each transfer, wrap after MEM_WORDS words, rewind on start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= BASE_ADDR[ADDR_W-1:0];
            word_idx <= '0;
        end else if (start) begin
            out_addr <= BASE_ADDR[ADDR_W-1:0];
            word_idx <= '0;
        end else if (xfer) begin
            if (word_idx == LAST_IDX) begin
                out_addr <= BASE_ADDR[ADDR_W-1:0];
                word_idx <= '0;
            end else begin
                out_addr <= out_addr + ADDR_W'(4);
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    // Saturating count of substituted NOPs that actually reached memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (start) begin
            err_count <= '0;
        end else if (xfer && out_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader with a 4-word memory and non-zero base address.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected words are hand-assembled RV32I encodings.
module tb_inst_encode_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_funct3;
    logic        in_f7b5;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    int vectors;
    int miscompares;

    inst_encode_loader #(
        .BASE_ADDR (BASE),
        .ADDR_W    (32),
        .MEM_WORDS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_funct3 (in_funct3),
        .in_f7b5   (in_f7b5),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [3:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
        in_op     = op;
        in_funct3 = f3;
        in_f7b5   = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    task automatic word(input string tag, input logic [31:0] inst,
                        input logic [31:0] addr, input logic err);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".inst"},  out_inst, inst);
        chk({tag, ".addr"},  out_addr, addr);
        chk({tag, ".err"},   {31'b0, out_err}, {31'b0, err});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        put(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);

        // Reset state
        #12;
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.inst",  out_inst, 32'd0);
        chk("rst.err",   {31'b0, out_err}, 32'd0);
        chk("rst.addr",  out_addr, BASE);
        chk("rst.errc",  {24'b0, err_count}, 32'd0);
        chk("rst.ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream; fifth word wraps the 4-word memory
        in_valid = 1'b1;
        put(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk); word("addi", 32'h0050_0093, BASE, 1'b0);
        put(4'd0, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        @(negedge clk); word("lui", 32'h1234_52B7, BASE + 32'd4, 1'b0);
        put(4'd2, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        @(negedge clk); word("jal", 32'h0080_00EF, BASE + 32'd8, 1'b0);
        put(4'd4, 3'b100, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4);
        @(negedge clk); word("blt", 32'hFE20_CEE3, BASE + 32'd12, 1'b0);
        put(4'd6, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        @(negedge clk); word("sw_wrap", 32'h0020_A423, BASE, 1'b0);

        // Illegal immediates become NOPs but still consume addresses
        put(4'd2, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
        @(negedge clk); word("jal_odd", NOP, BASE + 32'd4, 1'b1);
        put(4'd0, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1);
        @(negedge clk); word("lui_low", NOP, BASE + 32'd8, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle1.valid", {31'b0, out_valid}, 32'd0);
        chk("errc2", {24'b0, err_count}, 32'd2);

        // Shift with f7b5, OP sub, illegal op, JALR with funct3 forced to zero
        in_valid = 1'b1;
        put(4'd7, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3);
        @(negedge clk); word("srai", 32'h4031_5093, BASE + 32'd12, 1'b0);
        put(4'd8, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk); word("sub", 32'h4020_81B3, BASE, 1'b0);
        put(4'd9, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk); word("badop", NOP, BASE + 32'd4, 1'b1);
        put(4'd3, 3'b111, 1'b0, 5'd1, 5'd5, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk); word("jalr", 32'hFFF2_80E7, BASE + 32'd8, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("errc3", {24'b0, err_count}, 32'd3);

        // Downstream stall for 5 cycles with a bundle waiting
        in_valid  = 1'b1;
        out_ready = 1'b0;
        put(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk); word("stall_w", 32'h0050_0093, BASE + 32'd12, 1'b0);
        put(4'd6, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        for (int i = 0; i < 5; i++) begin
            chk("stall.ready", {31'b0, in_ready}, 32'd0);
            chk("stall.inst",  out_inst, 32'h0050_0093);
            chk("stall.addr",  out_addr, BASE + 32'd12);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk); word("rel_sw", 32'h0020_A423, BASE, 1'b0);
        put(4'd0, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        @(negedge clk); word("rel_lui", 32'h1234_52B7, BASE + 32'd4, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel.drain", {31'b0, out_valid}, 32'd0);

        // start drops a stalled word and rewinds
        in_valid  = 1'b1;
        out_ready = 1'b0;
        put(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk); word("pre_start", 32'h0050_0093, BASE + 32'd8, 1'b0);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start.valid", {31'b0, out_valid}, 32'd0);
        chk("start.addr",  out_addr, BASE);
        chk("start.errc",  {24'b0, err_count}, 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        put(4'd0, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1);
        @(negedge clk); word("post_start", NOP, BASE, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("errc1", {24'b0, err_count}, 32'd1);

        // start with a same-cycle accept keeps the new bundle at BASE
        in_valid  = 1'b1;
        out_ready = 1'b0;
        put(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk); word("held", 32'h0050_0093, BASE + 32'd4, 1'b0);
        out_ready = 1'b1;
        start     = 1'b1;
        put(4'd2, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        word("start_acc", 32'h0080_00EF, BASE, 1'b0);
        chk("start_acc.errc", {24'b0, err_count}, 32'd0);
        @(negedge clk);

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        put(4'd2, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
        @(negedge clk); word("pre_rst_err", NOP, BASE + 32'd4, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst.errc", {24'b0, err_count}, 32'd1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        put(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk); word("pre_rst", 32'h0050_0093, BASE + 32'd8, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", {31'b0, out_valid}, 32'd0);
        chk("arst.addr",  out_addr, BASE);
        chk("arst.errc",  {24'b0, err_count}, 32'd0);
        chk("arst.inst",  out_inst, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        put(4'd7, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3);
        @(negedge clk); word("post_rst", 32'h4031_5093, BASE, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
